// File: rtl/ct_soc_l2flush_ctrl_if.sv
// Handshake bundle between the power manager, the L2-flush initiator and the CPU pads.
// master: the flush controller; slave: the power-manager / CPU side that drives its inputs.
interface ct_soc_l2flush_ctrl_if #(
  parameter int unsigned TO_W = 16
);
  logic            pm_flush_req;
  logic            pm_abort;
  logic            cfg_wait_noop;
  logic [TO_W-1:0] cfg_timeout;
  logic            cpu_pad_l2cache_flush_done;
  logic            cpu_pad_no_op;
  logic            pad_cpu_l2cache_flush_req;
  logic            pm_flush_busy;
  logic            pm_flush_ack;
  logic            pm_flush_err;

  modport master (
    input  pm_flush_req,
    input  pm_abort,
    input  cfg_wait_noop,
    input  cfg_timeout,
    input  cpu_pad_l2cache_flush_done,
    input  cpu_pad_no_op,
    output pad_cpu_l2cache_flush_req,
    output pm_flush_busy,
    output pm_flush_ack,
    output pm_flush_err
  );

  modport slave (
    output pm_flush_req,
    output pm_abort,
    output cfg_wait_noop,
    output cfg_timeout,
    output cpu_pad_l2cache_flush_done,
    output cpu_pad_no_op,
    input  pad_cpu_l2cache_flush_req,
    input  pm_flush_busy,
    input  pm_flush_ack,
    input  pm_flush_err
  );
endinterface

// File: rtl/ct_soc_l2flush_ctrl.sv
// SoC-side initiator of the CPU L2-cache flush pad handshake: 4-phase req/done,
// optional no-op wait, per-phase timeout and abort.
module ct_soc_l2flush_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_W        = 16
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  ct_soc_l2flush_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_NOOP,
    S_REL,
    S_ACK,
    S_TMO
  } state_e;

  state_e                 state_q, state_d;
  logic [TO_W-1:0]        timer_q, timer_d;
  logic [TO_W-1:0]        tmo_cfg_q, tmo_cfg_d;
  logic                   wait_noop_q, wait_noop_d;
  logic                   flush_req_q;
  logic                   ack_q;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] done_sync_q;
  logic [SYNC_STAGES-1:0] noop_sync_q;
  logic                   done_s;
  logic                   noop_s;
  logic                   phase_expired;
  logic                   in_phase;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      done_sync_q <= '0;
      noop_sync_q <= '0;
    end else begin
      done_sync_q[0] <= bus.cpu_pad_l2cache_flush_done;
      noop_sync_q[0] <= bus.cpu_pad_no_op;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        done_sync_q[i] <= done_sync_q[i-1];
        noop_sync_q[i] <= noop_sync_q[i-1];
      end
    end
  end

  assign done_s = done_sync_q[SYNC_STAGES-1];
  assign noop_s = noop_sync_q[SYNC_STAGES-1];

  assign in_phase      = (state_q == S_REQ) || (state_q == S_NOOP) || (state_q == S_REL);
  assign phase_expired = (tmo_cfg_q != '0) && (timer_q == (tmo_cfg_q - TO_W'(1)));

  // Within a phase: abort beats a normal exit, a normal exit beats expiry.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    tmo_cfg_d   = tmo_cfg_q;
    wait_noop_d = wait_noop_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.pm_flush_req) begin
          tmo_cfg_d   = bus.cfg_timeout;
          wait_noop_d = bus.cfg_wait_noop;
          if (done_s) err_d   = 1'b1;
          else        state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.pm_abort)   state_d = S_TMO;
        else if (done_s)    state_d = wait_noop_q ? S_NOOP : S_REL;
        else if (phase_expired) state_d = S_TMO;
      end
      S_NOOP: begin
        if (bus.pm_abort)   state_d = S_TMO;
        else if (noop_s)    state_d = S_REL;
        else if (phase_expired) state_d = S_TMO;
      end
      S_REL: begin
        if (bus.pm_abort)   state_d = S_TMO;
        else if (!done_s)   state_d = S_ACK;
        else if (phase_expired) state_d = S_TMO;
      end
      S_ACK: state_d = S_IDLE;
      S_TMO: begin
        if (!done_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (in_phase && (timer_q != '1)) begin
      timer_d = timer_q + TO_W'(1);
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tmo_cfg_q   <= '0;
      wait_noop_q <= 1'b0;
      flush_req_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tmo_cfg_q   <= tmo_cfg_d;
      wait_noop_q <= wait_noop_d;
      flush_req_q <= (state_d == S_REQ) || (state_d == S_NOOP);
      ack_q       <= (state_d == S_ACK);
      err_q       <= err_d;
    end
  end

  assign bus.pad_cpu_l2cache_flush_req = flush_req_q;
  assign bus.pm_flush_busy             = (state_q != S_IDLE);
  assign bus.pm_flush_ack              = ack_q;
  assign bus.pm_flush_err              = err_q;

endmodule

// File: tb/tb_ct_soc_l2flush_ctrl.sv
// Bench for ct_soc_l2flush_ctrl: a behavioural CPU responder plus an event-time
// model of the handshake (phase lengths, timeout, abort) predicting req/ack/err.
module tb_ct_soc_l2flush_ctrl;
  localparam int unsigned TO_W = 16;
  localparam int MAXC = 400;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ct_soc_l2flush_ctrl_if #(.TO_W(TO_W)) bus ();

  ct_soc_l2flush_ctrl #(.SYNC_STAGES(2), .TO_W(TO_W)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One phase of the handshake: the exit is seen exit_k cycles after entry.
  function automatic void phase(input int entry, input int exit_k, input int t,
                                input int ab, output int nx, output bit tmo);
    int len;
    tmo = 1'b0;
    len = exit_k + 1;
    if (t != 0 && exit_k > t - 1) begin
      len = t;
      tmo = 1'b1;
    end
    if (ab >= entry && ab < entry + len) begin
      len = ab - entry + 1;
      tmo = 1'b1;
    end
    nx = entry + len;
  endfunction

  // Cycle 0 = pm_flush_req cycle; done rises d cycles after req is seen high,
  // falls e cycles after req is seen low; no_op rises n cycles after done.
  function automatic void model(input int d, input int e, input int n, input bit wn,
                                input int t, input int ab,
                                output int x_hi, output int x_ack, output int x_err);
    int nx, fall, rise, df, ex;
    bit tmo;
    x_ack = -1;
    x_err = -1;
    rise  = 1 + d;
    phase(1, d + 2, t, ab, nx, tmo);
    if (!tmo && wn) phase(nx, (n > 1) ? n - 1 : 0, t, ab, nx, tmo);
    fall = nx;
    if (!tmo) begin
      phase(fall, e + 2, t, ab, nx, tmo);
      if (!tmo) x_ack = nx;
    end
    if (tmo) begin
      if (rise > fall - 1) begin
        x_err = nx + 1;
      end else begin
        df = fall + e;
        ex = (nx < rise + 2 || nx > df + 1) ? nx : df + 2;
        x_err = ex + 1;
      end
    end
    x_hi = fall - 1;
  endfunction

  task automatic settle();
    bus.pm_flush_req = 1'b0;
    bus.pm_abort = 1'b0;
    bus.cpu_pad_l2cache_flush_done = 1'b0;
    bus.cpu_pad_no_op = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_txn(input int d, input int e, input int n, input bit wn,
                         input int t, input int ab, input string tag);
    int hi_cnt = 0, lo_cnt = 0, dn_cnt = 0;
    bit done = 1'b0, noop = 1'b0;
    int req_hi = 0, ack_n = 0, ack_c = -1, err_n = 0, err_c = -1, overlap = 0;
    int quiet = 0, c = 0;
    bit finished = 1'b0;
    int x_hi, x_ack, x_err;
    logic [31:0] tv;
    model(d, e, n, wn, t, ab, x_hi, x_ack, x_err);
    tv = t;
    bus.cfg_wait_noop = wn;
    bus.cfg_timeout   = tv[TO_W-1:0];
    for (c = 0; c < MAXC; c++) begin
      if (bus.pad_cpu_l2cache_flush_req) req_hi++;
      if (bus.pm_flush_ack) begin ack_n++; if (ack_c < 0) ack_c = c; end
      if (bus.pm_flush_err) begin err_n++; if (err_c < 0) err_c = c; end
      if (bus.pm_flush_ack && bus.pm_flush_err) overlap++;
      if (bus.pad_cpu_l2cache_flush_req) begin
        lo_cnt = 0;
        if (!done && hi_cnt >= d) done = 1'b1;
        hi_cnt++;
      end else begin
        hi_cnt = 0;
        if (done && lo_cnt >= e) done = 1'b0;
        lo_cnt++;
      end
      if (done) begin
        if (!noop && dn_cnt >= n) noop = 1'b1;
        dn_cnt++;
      end else begin
        noop = 1'b0;
        dn_cnt = 0;
      end
      bus.cpu_pad_l2cache_flush_done = done;
      bus.cpu_pad_no_op = noop;
      bus.pm_flush_req = (c <= 1);
      bus.pm_abort = (c == ab);
      if (bus.pm_flush_busy || bus.pm_flush_ack || bus.pm_flush_err) quiet = 0;
      else quiet++;
      if (c > 3 && quiet >= 6) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (finished !== 1'b1) begin
      failures++;
      $display("FAIL %s completion got=not_idle_after_%0d exp=idle", tag, MAXC);
    end
    checks++;
    if (req_hi !== x_hi) begin
      failures++;
      $display("FAIL %s req_high_cycles got=%0d exp=%0d", tag, req_hi, x_hi);
    end
    checks++;
    if (ack_n !== ((x_ack >= 0) ? 1 : 0) || ack_c !== x_ack) begin
      failures++;
      $display("FAIL %s ack got=n%0d@%0d exp=@%0d", tag, ack_n, ack_c, x_ack);
    end
    checks++;
    if (err_n !== ((x_err >= 0) ? 1 : 0) || err_c !== x_err) begin
      failures++;
      $display("FAIL %s err got=n%0d@%0d exp=@%0d", tag, err_n, err_c, x_err);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL %s ack_err_overlap got=%0d exp=0", tag, overlap);
    end
    settle();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.pad_cpu_l2cache_flush_req, bus.pm_flush_busy, bus.pm_flush_ack, bus.pm_flush_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000",
               {bus.pad_cpu_l2cache_flush_req, bus.pm_flush_busy, bus.pm_flush_ack, bus.pm_flush_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pad_cpu_l2cache_flush_req, bus.pm_flush_busy, bus.pm_flush_ack, bus.pm_flush_err} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0000",
               {bus.pad_cpu_l2cache_flush_req, bus.pm_flush_busy, bus.pm_flush_ack, bus.pm_flush_err});
    end
  endtask

  task automatic test_nominal();
    run_txn(2, 2, 1, 1'b0, 0, -1, "nominal");
    run_txn(0, 0, 1, 1'b0, 0, -1, "min_latency");
  endtask

  task automatic test_noop_wait();
    run_txn(2, 2, 10, 1'b1, 0, -1, "noop_wait");
  endtask

  task automatic test_timeout();
    run_txn(1000, 0, 1, 1'b0, 8, -1, "timeout_req");
    run_txn(1, 12, 1, 1'b0, 6, -1, "timeout_rel");
  endtask

  task automatic test_stale_done();
    int err_n = 0, err_c = -1, bad = 0;
    bus.cpu_pad_l2cache_flush_done = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (bus.pm_flush_err) begin err_n++; if (err_c < 0) err_c = c; end
      if (bus.pad_cpu_l2cache_flush_req || bus.pm_flush_busy || bus.pm_flush_ack) bad++;
      bus.pm_flush_req = (c == 0);
      @(negedge clk);
    end
    checks++;
    if (err_n !== 1 || err_c !== 1) begin
      failures++;
      $display("FAIL stale_done_err got=n%0d@%0d exp=n1@1", err_n, err_c);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stale_done_idle got=%0d_active_cycles exp=0", bad);
    end
    settle();
  endtask

  task automatic test_abort_and_boundary();
    run_txn(2, 3, 20, 1'b1, 0, 8, "abort_noop");
    run_txn(7, 1, 1, 1'b0, 10, -1, "boundary_exit");
    run_txn(8, 1, 1, 1'b0, 10, -1, "boundary_expire");
  endtask

  task automatic test_reset_mid_req();
    bus.cfg_wait_noop = 1'b0;
    bus.cfg_timeout = '0;
    bus.pm_flush_req = 1'b1;
    @(negedge clk);
    bus.pm_flush_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pad_cpu_l2cache_flush_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_req_active got=%b exp=1", bus.pad_cpu_l2cache_flush_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pad_cpu_l2cache_flush_req, bus.pm_flush_busy, bus.pm_flush_ack, bus.pm_flush_err} !== 4'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b exp=0000",
               {bus.pad_cpu_l2cache_flush_req, bus.pm_flush_busy, bus.pm_flush_ack, bus.pm_flush_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(1, 1, 1, 1'b0, 0, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 40; i++) begin
      int d, e, n, t, ab;
      bit wn;
      d  = int'($urandom_range(0, 8));
      e  = int'($urandom_range(0, 8));
      n  = int'($urandom_range(1, 10));
      wn = 1'($urandom_range(0, 1));
      t  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 20));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      run_txn(d, e, n, wn, t, ab, $sformatf("rand%0d_d%0d_e%0d_n%0d_w%0d_t%0d_a%0d", i, d, e, n, wn, t, ab));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.pm_flush_req = 1'b0;
    bus.pm_abort = 1'b0;
    bus.cfg_wait_noop = 1'b0;
    bus.cfg_timeout = '0;
    bus.cpu_pad_l2cache_flush_done = 1'b0;
    bus.cpu_pad_no_op = 1'b0;
    test_reset();
    test_nominal();
    test_noop_wait();
    test_timeout();
    test_stale_done();
    test_abort_and_boundary();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
